phat_hien_chuoi_1111: RTL and testbench

- Serial bit-stream detector that flags four consecutive 1s ("1111") on input w.
- Moore FSM; output y is a registered function of the state only.
- Sits on a one-bit serial data path and feeds downstream logic with a match flag, plus a saturating match counter and a state debug port.

---
 rtl/phat_hien_chuoi_1111.sv | 78 +++++++
 tb/tb_phat_hien_chuoi_1111.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/phat_hien_chuoi_1111.sv
// ----------------------------------------------------------------------------
// phat_hien_chuoi_1111
// Serial "1111" detector (Moore FSM) with a saturating match counter.
//
// Ports:
//   clk        in   1      system clock, all state updates on rising edge
//   reset      in   1      synchronous active-high reset (priority over w)
//   w          in   1      serial data bit, sampled every rising edge
//   y          out  1      match flag, high while the FSM sits in S4
//   match_cnt  out  CNT_W  detections since reset, saturates at all-ones
//   state_dbg  out  3      current state encoding (debug only)
//
// Parameters:
//   OVERLAP    1 = a run of N>=4 ones holds y for N-3 cycles,
//              0 = after a match the next 1 starts a fresh run
//   CNT_W      width of match_cnt
// ----------------------------------------------------------------------------
module phat_hien_chuoi_1111 #(
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             y_q;
    logic [CNT_W-1:0] cnt_q;

    // Next-state decode. Unused codes 5..7 fall through to S0.
    always_comb begin
        state_d = S0;
        if (w) begin
            case (state_q)
                S0:      state_d = S1;
                S1:      state_d = S2;
                S2:      state_d = S3;
                S3:      state_d = S4;
                S4:      state_d = OVERLAP ? S4 : S1;
                default: state_d = S0;
            endcase
        end
    end

    // y is registered from the next state so it equals (state_q == S4)
    // without any combinational path from w to the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
            y_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= (state_d == S4);
            if ((state_d == S4) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign y         = y_q;
    assign match_cnt = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_phat_hien_chuoi_1111.sv
// ----------------------------------------------------------------------------
// tb_phat_hien_chuoi_1111
// Directed bench for phat_hien_chuoi_1111. Three instances share clk, reset
// and w: default parameters, OVERLAP=0, and CNT_W=2 for saturation.
// ----------------------------------------------------------------------------
module tb_phat_hien_chuoi_1111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       w = 1'b0;

    logic       y_a, y_n, y_s;
    logic [7:0] cnt_a, cnt_n;
    logic [1:0] cnt_s;
    logic [2:0] dbg_a, dbg_n, dbg_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phat_hien_chuoi_1111 #(.OVERLAP(1'b1), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .w(w),
        .y(y_a), .match_cnt(cnt_a), .state_dbg(dbg_a)
    );

    phat_hien_chuoi_1111 #(.OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .clk(clk), .reset(reset), .w(w),
        .y(y_n), .match_cnt(cnt_n), .state_dbg(dbg_n)
    );

    phat_hien_chuoi_1111 #(.OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .w(w),
        .y(y_s), .match_cnt(cnt_s), .state_dbg(dbg_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive w, take one rising edge, sample 1 time unit later.
    task automatic step(input logic wv);
        w = wv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        w     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Reset state
        do_reset();
        chk("rst_y", y_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_dbg", dbg_a, 0);

        // Reset mid-run after three 1s, reset beats w=1
        step(1'b1); step(1'b1); step(1'b1);
        chk("pre_rst_dbg", dbg_a, 3);
        reset = 1'b1;
        step(1'b1);
        chk("midrst_dbg", dbg_a, 0);
        chk("midrst_y", y_a, 0);
        reset = 1'b0;
        step(1'b1);
        chk("after_rst_dbg", dbg_a, 1);
        chk("after_rst_y", y_a, 0);

        // Basic match
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step(1'b1);
            chk($sformatf("basic_dbg%0d", k), dbg_a, k);
            chk($sformatf("basic_y%0d", k), y_a, (k == 4) ? 1 : 0);
        end
        chk("basic_cnt", cnt_a, 1);
        // w drops between edges: y must not follow w
        w = 1'b0;
        #2;
        chk("no_comb_path", y_a, 1);
        step(1'b0);
        chk("basic_end_y", y_a, 0);
        chk("basic_end_dbg", dbg_a, 0);

        // Broken run 1,1,1,0,1,1,1
        do_reset();
        begin
            logic [6:0] pat;
            pat = 7'b1110111;
            for (int k = 6; k >= 0; k--) begin
                step(pat[k]);
                chk($sformatf("broken_y%0d", 6 - k), y_a, 0);
            end
        end
        chk("broken_cnt", cnt_a, 0);

        // Back-to-back runs 1,1,1,1,0,1,1,1,1,1 with overlap
        do_reset();
        step(1'b1); step(1'b1); step(1'b1); step(1'b1);
        chk("b2b_run1_y", y_a, 1);
        step(1'b0);
        chk("b2b_gap_y", y_a, 0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1);
            chk($sformatf("b2b_run2_y%0d", k), y_a, (k >= 4) ? 1 : 0);
        end
        chk("b2b_cnt", cnt_a, 3);

        // Non-overlap: 8 ones, y after edges 4 and 8 only
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1);
            chk($sformatf("novl_y%0d", k), y_n, ((k % 4) == 0) ? 1 : 0);
            chk($sformatf("novl_dbg%0d", k), dbg_n, ((k - 1) % 4) + 1);
        end
        chk("novl_cnt", cnt_n, 2);

        // Saturation with CNT_W=2: 10 ones
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(1'b1);
            chk($sformatf("sat_cnt%0d", k), cnt_s, (k < 4) ? 0 : ((k - 3 > 3) ? 3 : k - 3));
            chk($sformatf("sat_y%0d", k), y_s, (k >= 4) ? 1 : 0);
        end

        // Reset clears a saturated counter
        do_reset();
        chk("sat_clear", cnt_s, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
